// File: rtl/dtm_dmi_pkg.sv
// Shared DMI bus definitions (dbg_defines): widths, op/status codes, FSM states.
// The response timeout is compiled in only when DTM_DMI_TIMEOUT_EN is defined.
package dtm_dmi_pkg;

    localparam int unsigned ABITS_DEF    = 7;
    localparam int unsigned DBUS_M_WIDTH = ABITS_DEF + 34;
    localparam int unsigned DBUS_S_WIDTH = 34;

    typedef enum logic [1:0] {
        DMI_OP_NOP   = 2'd0,
        DMI_OP_READ  = 2'd1,
        DMI_OP_WRITE = 2'd2,
        DMI_OP_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        DMI_ST_OK     = 2'd0,
        DMI_ST_RSVD   = 2'd1,
        DMI_ST_FAILED = 2'd2,
        DMI_ST_BUSY   = 2'd3
    } dmi_st_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } dmi_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dm_resp_t;

endpackage

// File: rtl/dtm_dmi_if.sv
// DTM<->DM debug bus: request channel from the DTM, response channel from the DM.
interface dtm_dmi_if
    import dtm_dmi_pkg::*;
#(
    parameter int unsigned ABITS = 7
);
    logic                    dtm_req_valid;
    logic                    dtm_req_ready;
    logic [ABITS+33:0]       dtm_req_bits;
    logic                    dm_resp_valid;
    logic                    dm_resp_ready;
    logic [DBUS_S_WIDTH-1:0] dm_resp_bits;

    modport master (
        output dtm_req_valid, dtm_req_bits, dm_resp_ready,
        input  dtm_req_ready, dm_resp_valid, dm_resp_bits
    );

    modport slave (
        input  dtm_req_valid, dtm_req_bits, dm_resp_ready,
        output dtm_req_ready, dm_resp_valid, dm_resp_bits
    );
endinterface

// File: rtl/dtm_dmi_timeout.sv
// Access timeout counter; expired_o stays set from the CYCLES-th active cycle until clr_i.
module dtm_dmi_timeout #(
    parameter int unsigned CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired_q, expired_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
        expired_d = (clr_i ? 1'b0 : expired_q) | (cnt_d == CW'(CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;
endmodule

// File: rtl/dtm_dmi.sv
// DTM-side DMI master: issues JTAG-latched accesses to the DM and keeps result/sticky status.
// Optional response timeout enabled by defining DTM_DMI_TIMEOUT_EN.
module dtm_dmi
    import dtm_dmi_pkg::*;
#(
    parameter int unsigned ABITS          = 7,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              dmi_update,
    input  logic [ABITS+33:0] dmi_wdata,
    input  logic              dmi_capture,
    output logic [ABITS+33:0] dmi_rdata,
    input  logic              dmireset,
    input  logic              dmihardreset,
    output logic              dmi_busy,
    dtm_dmi_if.master         dbus
);
    dmi_state_e       state_q, state_d;
    logic             req_valid_q, req_valid_d;
    logic             resp_ready_q, resp_ready_d;
    logic             busy_q, busy_d;
    logic [ABITS-1:0] addr_q, addr_d, last_addr_q, last_addr_d;
    logic [31:0]      data_q, data_d, last_data_q, last_data_d;
    logic [1:0]       op_q, op_d, status_q, status_d;
    logic             to_expired;
    dm_resp_t         rsp;

    logic [ABITS-1:0] wd_addr;
    logic [31:0]      wd_data;
    logic [1:0]       wd_op;

    assign wd_addr = dmi_wdata[ABITS+33:34];
    assign wd_data = dmi_wdata[33:2];
    assign wd_op   = dmi_wdata[1:0];
    assign rsp     = dm_resp_t'(dbus.dm_resp_bits);

`ifdef DTM_DMI_TIMEOUT_EN
    dtm_dmi_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk       (sys_clk),
        .rst       (sys_rst),
        .clr_i     ((state_q == ST_IDLE) && (state_d == ST_REQ)),
        .en_i      (state_q != ST_IDLE),
        .expired_o (to_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign to_expired     = 1'b0;
`endif

    // Sticky status: the first error after a clear is kept; a failure beats BUSY in the same cycle.
    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        resp_ready_d = resp_ready_q;
        addr_d       = addr_q;
        data_d       = data_q;
        op_d         = op_q;
        last_addr_d  = last_addr_q;
        last_data_d  = last_data_q;
        status_d     = dmireset ? DMI_ST_OK : status_q;

        if (dmihardreset) begin
            state_d      = ST_IDLE;
            req_valid_d  = 1'b0;
            resp_ready_d = 1'b0;
            status_d     = DMI_ST_OK;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (dmi_update && status_d == DMI_ST_OK) begin
                        last_addr_d = wd_addr;
                        if (wd_op == DMI_OP_READ || wd_op == DMI_OP_WRITE) begin
                            addr_d      = wd_addr;
                            data_d      = wd_data;
                            op_d        = wd_op;
                            state_d     = ST_REQ;
                            req_valid_d = 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (dbus.dtm_req_ready) begin
                        state_d      = ST_RESP;
                        req_valid_d  = 1'b0;
                        resp_ready_d = 1'b1;
                    end
                end
                ST_RESP: begin
                    if (dbus.dm_resp_valid) begin
                        if (op_q == DMI_OP_READ) begin
                            last_data_d = rsp.data;
                        end
                        if (rsp.resp[1] && status_d == DMI_ST_OK) begin
                            status_d = DMI_ST_FAILED;
                        end
                        state_d      = ST_IDLE;
                        resp_ready_d = 1'b0;
                    end
                end
                default: begin
                    state_d      = ST_IDLE;
                    req_valid_d  = 1'b0;
                    resp_ready_d = 1'b0;
                end
            endcase

            if (to_expired && state_q != ST_IDLE && state_d == state_q) begin
                state_d      = ST_IDLE;
                req_valid_d  = 1'b0;
                resp_ready_d = 1'b0;
                if (status_d == DMI_ST_OK) begin
                    status_d = DMI_ST_FAILED;
                end
            end

            if (state_q != ST_IDLE && (dmi_update || dmi_capture) && status_d == DMI_ST_OK) begin
                status_d = DMI_ST_BUSY;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            op_q         <= '0;
            last_addr_q  <= '0;
            last_data_q  <= '0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            op_q         <= op_d;
            last_addr_q  <= last_addr_d;
            last_data_q  <= last_data_d;
            status_q     <= status_d;
        end
    end

    assign dbus.dtm_req_valid = req_valid_q;
    assign dbus.dtm_req_bits  = {addr_q, data_q, op_q};
    assign dbus.dm_resp_ready = resp_ready_q;
    assign dmi_rdata          = {last_addr_q, last_data_q, status_q};
    assign dmi_busy           = busy_q;
endmodule

// File: tb/tb_dtm_dmi.sv
// Bench for dtm_dmi: directed scenarios plus random traffic against a transaction-level model.
module tb_dtm_dmi;
    localparam int AB = 7;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst, upd, cap, drst, dhrst;
    logic [AB+33:0] wdata;
    logic [AB+33:0] rdata;
    logic          busy;
    int            checks = 0;
    int            errors = 0;
    int            hs_cnt = 0;
    bit            chk_en = 1'b0;

    dtm_dmi_if #(.ABITS(AB)) bus ();

    dtm_dmi #(.ABITS(AB), .TIMEOUT_CYCLES(TO)) u_dut (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .dmi_update   (upd),
        .dmi_wdata    (wdata),
        .dmi_capture  (cap),
        .dmi_rdata    (rdata),
        .dmireset     (drst),
        .dmihardreset (dhrst),
        .dmi_busy     (busy),
        .dbus         (bus)
    );

    always #5 clk = ~clk;

    // Model: an access is "in flight" from acceptance until response/abort; "acc" = request taken.
    logic          m_fl = 0, m_acc = 0;
    int            m_el = 0;
    logic [1:0]    m_st = 0;
    logic [AB-1:0] m_la = 0;
    logic [31:0]   m_ld = 0;
    logic [AB+33:0] m_rq = 0;

    always @(posedge clk) begin : model
        logic fl, acc, prog;
        int el;
        logic [1:0] st;
        logic [AB-1:0] la;
        logic [31:0] ld;
        logic [AB+33:0] rq;
        fl = m_fl; acc = m_acc; el = m_el; la = m_la; ld = m_ld; rq = m_rq;
        st = drst ? 2'd0 : m_st;
        if (rst) begin
            fl = 0; acc = 0; el = 0; st = 0; la = 0; ld = 0; rq = 0;
        end else if (dhrst) begin
            fl = 0; acc = 0; st = 0;
        end else if (!fl) begin
            if (upd && st == 2'd0) begin
                la = wdata[AB+33:34];
                if (wdata[1:0] == 2'd1 || wdata[1:0] == 2'd2) begin
                    fl = 1; acc = 0; el = 0; rq = wdata;
                end
            end
        end else begin
            prog = 0;
            el = el + 1;
            if (!acc) begin
                if (bus.dtm_req_ready) begin acc = 1; prog = 1; end
            end else if (bus.dm_resp_valid) begin
                if (rq[1:0] == 2'd1) ld = bus.dm_resp_bits[33:2];
                if (bus.dm_resp_bits[1:0] >= 2'd2 && st == 2'd0) st = 2'd2;
                fl = 0; prog = 1;
            end
`ifdef DTM_DMI_TIMEOUT_EN
            if (!prog && el >= TO) begin
                fl = 0; acc = 0;
                if (st == 2'd0) st = 2'd2;
            end
`endif
            if ((upd || cap) && st == 2'd0) st = 2'd3;
        end
        m_fl <= fl; m_acc <= acc; m_el <= el; m_st <= st; m_la <= la; m_ld <= ld; m_rq <= rq;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_valid",  64'(bus.dtm_req_valid), 64'(m_fl && !m_acc));
            chk("resp_ready", 64'(bus.dm_resp_ready), 64'(m_fl && m_acc));
            chk("busy",       64'(busy), 64'(m_fl));
            chk("req_bits",   64'(bus.dtm_req_bits), 64'(m_rq));
            chk("rdata",      64'(rdata), 64'({m_la, m_ld, m_st}));
            if (bus.dtm_req_valid && bus.dtm_req_ready) hs_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input logic [AB-1:0] a, input logic [31:0] d, input logic [1:0] op);
        wdata = {a, d, op};
        upd = 1'b1;
        cyc(1);
        upd = 1'b0;
    endtask

    initial begin
        int hs0;
        rst = 1; upd = 0; cap = 0; drst = 0; dhrst = 0; wdata = '0;
        bus.dtm_req_ready = 0; bus.dm_resp_valid = 0; bus.dm_resp_bits = '0;
        chk_en = 1'b1;
        cyc(2);
        chk("reset_rdata", 64'(rdata), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 0;
        cyc(1);

        // READ 0x10, DM always ready and responding
        bus.dtm_req_ready = 1; bus.dm_resp_valid = 1; bus.dm_resp_bits = {32'hDEADBEEF, 2'd0};
        pulse(7'h10, 32'h0, 2'd1);
        chk("rd_valid_n1", 64'(bus.dtm_req_valid), 64'd1);
        cyc(1);
        chk("rd_resp_ready", 64'(bus.dm_resp_ready), 64'd1);
        cyc(1);
        chk("rd_busy_done", 64'(busy), 64'd0);
        chk("rd_rdata", 64'(rdata), 64'({7'h10, 32'hDEADBEEF, 2'd0}));

        // WRITE with ready held low; early response valid must be ignored
        bus.dtm_req_ready = 0;
        hs0 = hs_cnt;
        pulse(7'h04, 32'h1, 2'd2);
        for (int i = 0; i < 5; i++) begin
            chk("wr_bits_stable", 64'(bus.dtm_req_bits), 64'({7'h04, 32'h1, 2'd2}));
            cyc(1);
        end
        bus.dtm_req_ready = 1;
        cyc(2);
        chk("wr_one_handshake", 64'(hs_cnt - hs0), 64'd1);
        chk("wr_rdata", 64'(rdata), 64'({7'h04, 32'hDEADBEEF, 2'd0}));

        // capture during RESP -> BUSY; next READ dropped; dmireset recovers
        bus.dm_resp_valid = 0;
        pulse(7'h20, 32'h0, 2'd1);
        cyc(1);
        cap = 1; cyc(1); cap = 0;
        chk("cap_status_busy", 64'(rdata[1:0]), 64'd3);
        bus.dm_resp_bits = {32'hCAFEF00D, 2'd0}; bus.dm_resp_valid = 1;
        cyc(1);
        chk("cap_rdata", 64'(rdata), 64'({7'h20, 32'hCAFEF00D, 2'd3}));
        pulse(7'h30, 32'h0, 2'd1);
        chk("cap_drop_valid", 64'(bus.dtm_req_valid), 64'd0);
        cyc(2);
        chk("cap_drop_addr", 64'(rdata[AB+33:34]), 64'h20);
        drst = 1; cyc(1); drst = 0;
        chk("dmireset_clear", 64'(rdata[1:0]), 64'd0);
        pulse(7'h31, 32'h0, 2'd1);
        chk("third_read_valid", 64'(bus.dtm_req_valid), 64'd1);
        cyc(2);
        chk("third_read_rdata", 64'(rdata), 64'({7'h31, 32'hCAFEF00D, 2'd0}));

        // failed response, later updates dropped, dmireset+update same cycle accepted
        bus.dm_resp_bits = {32'h12345678, 2'd2};
        pulse(7'h11, 32'h0, 2'd1);
        cyc(2);
        chk("fail_rdata", 64'(rdata), 64'({7'h11, 32'h12345678, 2'd2}));
        pulse(7'h12, 32'h0, 2'd1);
        chk("fail_drop_valid", 64'(bus.dtm_req_valid), 64'd0);
        pulse(7'h13, 32'h0, 2'd0);
        chk("fail_drop_nop", 64'(rdata[AB+33:34]), 64'h11);
        bus.dm_resp_bits = {32'hA5A5A5A5, 2'd0};
        drst = 1;
        pulse(7'h14, 32'h0, 2'd1);
        drst = 0;
        chk("rst_upd_valid", 64'(bus.dtm_req_valid), 64'd1);
        cyc(2);
        chk("rst_upd_rdata", 64'(rdata), 64'({7'h14, 32'hA5A5A5A5, 2'd0}));
        pulse(7'h15, 32'h0, 2'd0);
        chk("nop_addr", 64'(rdata), 64'({7'h15, 32'hA5A5A5A5, 2'd0}));
        pulse(7'h16, 32'h0, 2'd3);
        chk("rsvd_addr", 64'(rdata), 64'({7'h16, 32'hA5A5A5A5, 2'd0}));

        // hard reset in RESP with status already BUSY and a same-cycle update
        bus.dm_resp_valid = 0;
        pulse(7'h22, 32'h0, 2'd1);
        cyc(1);
        cap = 1; cyc(1); cap = 0;
        dhrst = 1;
        pulse(7'h23, 32'h0, 2'd1);
        dhrst = 0;
        chk("hrst_resp_ready", 64'(bus.dm_resp_ready), 64'd0);
        chk("hrst_busy", 64'(busy), 64'd0);
        chk("hrst_status", 64'(rdata[1:0]), 64'd0);
        cyc(1);
        chk("hrst_no_req", 64'(bus.dtm_req_valid), 64'd0);

        // DM never responds
        pulse(7'h40, 32'h0, 2'd1);
`ifdef DTM_DMI_TIMEOUT_EN
        cyc(7);
        chk("to_busy_before", 64'(busy), 64'd1);
        cyc(1);
        chk("to_busy_after", 64'(busy), 64'd0);
        chk("to_rdata", 64'(rdata), 64'({7'h40, 32'hA5A5A5A5, 2'd2}));
        drst = 1; cyc(1); drst = 0;
`else
        cyc(20);
        chk("wait_forever_busy", 64'(busy), 64'd1);
        dhrst = 1; cyc(1); dhrst = 0;
        chk("wait_abort_busy", 64'(busy), 64'd0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 499) == 0);
            upd   = ($urandom_range(0, 5) == 0);
            cap   = ($urandom_range(0, 15) == 0);
            drst  = ($urandom_range(0, 23) == 0);
            dhrst = ($urandom_range(0, 63) == 0);
            wdata = {7'($urandom), 32'($urandom), 2'($urandom)};
            bus.dtm_req_ready = 1'($urandom);
            bus.dm_resp_valid = 1'($urandom);
            bus.dm_resp_bits  = {32'($urandom), 2'($urandom)};
            cyc(1);
        end
        rst = 0; upd = 0; cap = 0; drst = 0; dhrst = 0;
        cyc(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dtm_dmi.md
# dtm_dmi

Debug Transport Module DMI master: the requester on the DTM↔DM debug bus. It takes a DMI access latched from the JTAG `dmi` register, issues it on the request channel (`dtm_req_*`), waits for the DM response (`dm_resp_*`), and holds the result and sticky status for the next JTAG capture. It sits between the JTAG TAP/DR logic and the debug module, in the `sys_clk` domain.

## Interface
- `ABITS`, 7: DMI address width.
- `TIMEOUT_CYCLES`, 255: response timeout in cycles; used only with `DTM_DMI_TIMEOUT_EN`.
- `sys_clk` in 1: the only clock.
- `sys_rst` in 1: synchronous, active-high reset.
- `dmi_update` in 1: one-cycle pulse; `dmi_wdata` holds a new access.
- `dmi_wdata` in ABITS+34: `{addr[ABITS-1:0], data[31:0], op[1:0]}`.
- `dmi_capture` in 1: one-cycle pulse; JTAG is capturing `dmi_rdata`.
- `dmi_rdata` out ABITS+34: `{last_addr, last_data, status[1:0]}`.
- `dmireset` in 1: pulse; clears sticky status.
- `dmihardreset` in 1: pulse; aborts any access and clears all status.
- `dmi_busy` out 1: an access is in flight.
- `dtm_req_valid` out 1: request valid.
- `dtm_req_ready` in 1: DM accepts the request.
- `dtm_req_bits` out `DBUS_M_WIDTH` (= ABITS+34): `{addr, data, op}`.
- `dm_resp_valid` in 1: response valid.
- `dm_resp_ready` out 1: ready to take the response.
- `dm_resp_bits` in `DBUS_S_WIDTH` (= 34): `{data[31:0], resp[1:0]}`.

## Operation
- Op encodings: 0 NOP, 1 READ, 2 WRITE, 3 reserved (treated as NOP).
- Status encodings: 0 OK, 2 FAILED, 3 BUSY. Status is sticky: once non-zero it is held until `dmireset` or `dmihardreset`.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - `dmi_update` with op 1 or 2 and status==0: latch addr, data and op; go to REQ.
  - Op 0 or 3: no bus activity; `last_addr` is updated.
  - Status≠0: the update is dropped.
- REQ: `dtm_req_valid`=1 and `dtm_req_bits` is held stable. On `valid&ready`, go to RESP.
- RESP: `dm_resp_ready`=1. On `valid&ready`:
  - Latch `dm_resp_bits.data` into `last_data`, but only for READ; a WRITE leaves `last_data` unchanged.
  - `resp`==2 or 3 sets status FAILED (2); `resp`==0 leaves it unchanged.
  - Go to IDLE.
- `dmi_update` or `dmi_capture` while not in IDLE sets status BUSY (3). The in-flight access still completes, and the new update is dropped.
- `dmi_busy` = (state≠IDLE).
- Reset values: state IDLE; `dtm_req_valid`=0, `dm_resp_ready`=0, `dmi_rdata`=0, `dmi_busy`=0, `dtm_req_bits`=0.

## Timing
- `dmi_update` in cycle N: `dtm_req_valid` rises in N+1.
- Handshake in cycle M: `dtm_req_valid` falls and `dm_resp_ready` rises in M+1.
- Response accepted in cycle K: `dm_resp_ready` and `dmi_busy` fall, and `dmi_rdata` is updated, in K+1.
- Best case (ready and valid already high): 3 cycles from update to IDLE.
- `dtm_req_valid` never drops without a handshake, except on `sys_rst` or `dmihardreset`.
- Priority, highest first: `sys_rst` > `dmihardreset` > `dmireset` > `dmi_update`/`dmi_capture`.
  - `dmireset` together with `dmi_update` in IDLE: status clears first and the update is accepted.
  - `dmihardreset` in REQ or RESP: forced to IDLE next cycle, handshake outputs drop, status cleared, any same-cycle update dropped.
- A response arriving in REQ (before request acceptance) is ignored: `dm_resp_ready` is 0 there.

## Configuration
- `DTM_DMI_TIMEOUT_EN` defined:
  - A counter runs in REQ and RESP and is cleared on entry to REQ.
  - When it reaches `TIMEOUT_CYCLES` without the awaited handshake: status FAILED (2), next state IDLE, outputs deasserted, `last_data` unchanged.
- Not defined: no counter; the block waits indefinitely.

## Structure
- `dbg_defines` holds `DBUS_M_WIDTH`, `DBUS_S_WIDTH`, the op encodings (`DMI_OP_NOP/READ/WRITE`), the status encodings (`DMI_ST_OK/FAILED/BUSY`), and the FSM state encodings.
- One sub-module, `dtm_dmi_timeout`: the counter with clear/enable/expire, instantiated only under `DTM_DMI_TIMEOUT_EN`.

## Test plan
- READ addr 0x10: DM ready at once and responds next cycle with data 0xDEADBEEF, resp 0.
  -> `dmi_rdata` = {0x10, 0xDEADBEEF, 0}; `dmi_busy` low 3 cycles after the update.
- WRITE addr 0x04, data 0x1: `dtm_req_ready` held low 5 cycles.
  -> `dtm_req_bits` stable throughout; one handshake only; `last_data` unchanged; status 0.
- `dmi_capture` during RESP, then a second READ.
  -> status 3; second READ not issued (no `dtm_req_valid`); after `dmireset`, a third READ is issued normally.
- DM response resp=2.
  -> status 2; later updates dropped until `dmireset`.
- `dmihardreset` in RESP.
  -> next cycle IDLE, `dm_resp_ready`=0, status 0, `dmi_busy`=0.
- With `DTM_DMI_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: DM never responds.
  -> status 2 and IDLE after 8 cycles.
